// File: rtl/pong_score_ctrl.sv
// -----------------------------------------------------------------------------
// pong_score_ctrl
//
// Game/score controller that sits downstream of the ball stage. It counts the
// point flags from the ball stage and keeps one score per player. It drives
// enablePong back to the ball stage, which gates ball motion and drawing.
// The game runs through four phases: idle, play, a pause after each point, and
// game over. The pause is timed in video frames. A frame tick is taken from the
// raster position o_x/o_y.
//
// Parameters
//   WIN_SCORE     points needed to win (1..15)
//   PAUSE_FRAMES  frames enablePong stays low after a non-winning point (1..255)
//   H_LAST        last active x; frame tick when o_x==H_LAST && o_y==V_LAST
//   V_LAST        last active y
//
// Ports
//   clk_in        in   1   board clock (shared with ball stage and VGA timing)
//   i_rst         in   1   asynchronous active-low reset
//   start_btn     in   1   asynchronous push button, active-high
//   o_x           in   10  current pixel x
//   o_y           in   9   current pixel y
//   pointPlayer1  in   1   player-1 scored flag (level, counted on rising edge)
//   pointPlayer2  in   1   player-2 scored flag (level, counted on rising edge)
//   enablePong    out  1   high only while in PLAY
//   score1        out  4   player-1 score, binary
//   score2        out  4   player-2 score, binary
//   winner        out  2   00 none, 01 player 1, 10 player 2
//   frame_tick    out  1   one-cycle pulse, one cycle after raster hits (H_LAST,V_LAST)
//
// Optional build macro SEG7_EN adds these ports:
//   hex_p1        out  7   score1 as an active-low seven-segment digit {g,f,e,d,c,b,a}
//   hex_p2        out  7   score2 as an active-low seven-segment digit {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module pong_score_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_FRAMES = 60,
    parameter int H_LAST       = 639,
    parameter int V_LAST       = 479
) (
    input  logic       clk_in,
    input  logic       i_rst,
    input  logic       start_btn,
    input  logic [9:0] o_x,
    input  logic [8:0] o_y,
    input  logic       pointPlayer1,
    input  logic       pointPlayer2,
    output logic       enablePong,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner,
    output logic       frame_tick
`ifdef SEG7_EN
    ,
    output logic [6:0] hex_p1,
    output logic [6:0] hex_p2
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    localparam logic [3:0] WIN_Q   = 4'(WIN_SCORE);
    localparam logic [7:0] PAUSE_Q = 8'(PAUSE_FRAMES);
    localparam logic [9:0] H_Q     = 10'(H_LAST);
    localparam logic [8:0] V_Q     = 9'(V_LAST);

    // Start button synchroniser and edge detector.
    logic start_ff1, start_ff2, start_prev;
    // Previous levels of the point flags, used for edge detection.
    logic p1_q, p2_q;

    logic [1:0] state, state_nxt;
    logic [7:0] pause_cnt, pause_nxt;
    logic [3:0] score1_nxt, score2_nxt;
    logic [1:0] winner_nxt;

    logic start_rise, p1_rise, p2_rise;

    assign start_rise = start_ff2 & ~start_prev;
    assign p1_rise    = pointPlayer1 & ~p1_q;
    assign p2_rise    = pointPlayer2 & ~p2_q;

    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        pause_nxt  = pause_cnt;
        score1_nxt = score1;
        score2_nxt = score2;
        winner_nxt = winner;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    state_nxt  = ST_PLAY;
                    score1_nxt = 4'd0;
                    score2_nxt = 4'd0;
                    winner_nxt = 2'b00;
                end
            end
            ST_PLAY: begin
                // A simultaneous edge on both flags is ambiguous and is dropped.
                if (p1_rise ^ p2_rise) begin
                    if (p1_rise) begin
                        if (score1 < WIN_Q) score1_nxt = score1 + 4'd1;
                        if (score1_nxt == WIN_Q) begin
                            state_nxt  = ST_OVER;
                            winner_nxt = 2'b01;
                        end else begin
                            state_nxt = ST_PAUSE;
                            pause_nxt = PAUSE_Q;
                        end
                    end else begin
                        if (score2 < WIN_Q) score2_nxt = score2 + 4'd1;
                        if (score2_nxt == WIN_Q) begin
                            state_nxt  = ST_OVER;
                            winner_nxt = 2'b10;
                        end else begin
                            state_nxt = ST_PAUSE;
                            pause_nxt = PAUSE_Q;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (frame_tick) begin
                    pause_nxt = pause_cnt - 8'd1;
                    if (pause_cnt == 8'd1) state_nxt = ST_PLAY;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments. Then every flop
    // samples the values from before the edge, and the simulator's evaluation
    // order cannot change the result.
    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            start_ff1  <= 1'b0;
            start_ff2  <= 1'b0;
            start_prev <= 1'b0;
            p1_q       <= 1'b0;
            p2_q       <= 1'b0;
            frame_tick <= 1'b0;
            state      <= ST_IDLE;
            enablePong <= 1'b0;
            pause_cnt  <= 8'd0;
            score1     <= 4'd0;
            score2     <= 4'd0;
            winner     <= 2'b00;
        end else begin
            start_ff1  <= start_btn;
            start_ff2  <= start_ff1;
            start_prev <= start_ff2;
            p1_q       <= pointPlayer1;
            p2_q       <= pointPlayer2;
            frame_tick <= (o_x == H_Q) && (o_y == V_Q);
            state      <= state_nxt;
            // enablePong is registered from the next state, so it tracks state
            // in the same cycle without a decode after the flop.
            enablePong <= (state_nxt == ST_PLAY);
            pause_cnt  <= pause_nxt;
            score1     <= score1_nxt;
            score2     <= score2_nxt;
            winner     <= winner_nxt;
        end
    end

`ifdef SEG7_EN
    function automatic logic [6:0] seg7_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Decoded from the score registers, so the display lags the score by one cycle.
    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            hex_p1 <= 7'b1000000;
            hex_p2 <= 7'b1000000;
        end else begin
            hex_p1 <= seg7_decode(score1);
            hex_p2 <= seg7_decode(score2);
        end
    end
`endif

endmodule

// File: tb/tb_pong_score_ctrl.sv
module tb_pong_score_ctrl;

    localparam int WIN = 7;
    localparam int PF  = 60;

    logic       clk_in = 1'b0;
    logic       i_rst = 1'b0;
    logic       start_btn = 1'b0;
    logic [9:0] o_x = '0;
    logic [8:0] o_y = '0;
    logic       p1 = 1'b0;
    logic       p2 = 1'b0;
    logic       enablePong;
    logic [3:0] score1, score2;
    logic [1:0] winner;
    logic       frame_tick;
`ifdef SEG7_EN
    logic [6:0] hex_p1, hex_p2;
`endif

    pong_score_ctrl #(
        .WIN_SCORE(WIN), .PAUSE_FRAMES(PF), .H_LAST(639), .V_LAST(479)
    ) dut (
        .clk_in(clk_in), .i_rst(i_rst), .start_btn(start_btn),
        .o_x(o_x), .o_y(o_y),
        .pointPlayer1(p1), .pointPlayer2(p2),
        .enablePong(enablePong), .score1(score1), .score2(score2),
        .winner(winner), .frame_tick(frame_tick)
`ifdef SEG7_EN
        , .hex_p1(hex_p1), .hex_p2(hex_p2)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: let an edge happen, then return on the falling edge.
    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic drive_raster(input bit last);
        if (last) begin
            o_x = 10'd639;
            o_y = 9'd479;
        end else begin
            o_x = 10'd0;
            o_y = 9'd0;
        end
    endtask

    // Send PF frame ticks. enablePong must stay low until the last one.
    task automatic run_pause(input string nm);
        for (int i = 1; i <= PF; i++) begin
            drive_raster(1);
            step();
            drive_raster(0);
            step();
            check(nm, enablePong, (i == PF) ? 1 : 0);
        end
    endtask

    task automatic wait_play(input string nm);
        int k;
        k = 0;
        while (!enablePong && k < 4) begin
            step();
            k++;
        end
        check(nm, enablePong, 1);
    endtask

    // ---------------- behavioural reference model ----------------
    // The model tracks game phase with flags and plain integer counts.
    bit       m_play, m_over;
    int       m_pause, m_s1, m_s2, m_win;
    bit       m_ft;
    bit [2:0] m_btn_hist;   // [0]=start_btn one edge ago, [1]=two edges ago, [2]=three
    bit       m_p1_prev, m_p2_prev;
    int       m_s1_d, m_s2_d;

    task automatic model_reset();
        m_play = 0; m_over = 0; m_pause = 0;
        m_s1 = 0; m_s2 = 0; m_win = 0; m_ft = 0;
        m_btn_hist = '0; m_p1_prev = 0; m_p2_prev = 0;
        m_s1_d = 0; m_s2_d = 0;
    endtask

    task automatic model_edge();
        bit s_rise, r1, r2, tick;
        s_rise = m_btn_hist[1] & ~m_btn_hist[2];
        r1 = p1 & ~m_p1_prev;
        r2 = p2 & ~m_p2_prev;
        tick = m_ft;
        m_s1_d = m_s1;
        m_s2_d = m_s2;
        if (!m_play && m_pause == 0) begin
            // idle or game over: waiting for a start press
            if (s_rise) begin
                m_play = 1; m_over = 0;
                m_s1 = 0; m_s2 = 0; m_win = 0;
            end
        end else if (m_play) begin
            if (r1 != r2) begin
                if (r1) m_s1++;
                else    m_s2++;
                m_play = 0;
                if (m_s1 == WIN) begin
                    m_over = 1; m_win = 1;
                end else if (m_s2 == WIN) begin
                    m_over = 1; m_win = 2;
                end else begin
                    m_pause = PF;
                end
            end
        end else if (tick) begin
            m_pause--;
            if (m_pause == 0) m_play = 1;
        end
        m_btn_hist = {m_btn_hist[1:0], start_btn};
        m_p1_prev = p1;
        m_p2_prev = p2;
        m_ft = (o_x == 10'd639) && (o_y == 9'd479);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in or negedge i_rst);
            if (!i_rst) model_reset();
            else        model_edge();
        end
    end

`ifdef SEG7_EN
    function automatic logic [6:0] seg_ref(input int v);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction
`endif

    // ---------------- directed table ----------------
    typedef struct {
        bit start, pa, pb, last;
        bit en; int s1, s2, win; bit ft;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ys [5];
        int ticks, bad;

        //         start pa pb last | en s1 s2 win ft
        tbl[0] = '{1, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[2] = '{0, 0, 0, 0,   1, 0, 0, 0, 0};   // start seen -> PLAY
        tbl[3] = '{0, 1, 1, 0,   1, 0, 0, 0, 0};   // both flags rise: ignored
        tbl[4] = '{0, 1, 1, 0,   1, 0, 0, 0, 0};
        tbl[5] = '{0, 0, 0, 1,   1, 0, 0, 0, 1};   // raster at last pixel
        tbl[6] = '{0, 0, 1, 0,   0, 0, 1, 0, 0};   // p2 point; tick on entry not counted
        tbl[7] = '{0, 0, 1, 0,   0, 0, 1, 0, 0};   // held flag
        tbl[8] = '{0, 1, 0, 0,   0, 0, 1, 0, 0};   // point edge in PAUSE ignored
        tbl[9] = '{0, 0, 0, 0,   0, 0, 1, 0, 0};

        // Reset state
        @(negedge clk_in);
        check("rst_en", enablePong, 0);
        check("rst_s1", score1, 0);
        check("rst_s2", score2, 0);
        check("rst_win", winner, 0);
        check("rst_ft", frame_tick, 0);
        i_rst = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            start_btn = tbl[i].start;
            p1 = tbl[i].pa;
            p2 = tbl[i].pb;
            drive_raster(tbl[i].last);
            step();
            check($sformatf("tbl%0d_en", i), enablePong, tbl[i].en);
            check($sformatf("tbl%0d_s1", i), score1, tbl[i].s1);
            check($sformatf("tbl%0d_s2", i), score2, tbl[i].s2);
            check($sformatf("tbl%0d_win", i), winner, tbl[i].win);
            check($sformatf("tbl%0d_ft", i), frame_tick, tbl[i].ft);
        end
        p1 = 0;
        run_pause("pause0_en");

        // Held-high point flag counts once, then a full pause
        p1 = 1;
        step();
        check("held_s1_first", score1, 1);
        check("held_en_low", enablePong, 0);
        run_pause("held_pause_en");
        check("held_s1_once", score1, 1);
        p1 = 0;
        step();

        // Player 2 reaches the winning score
        for (int k = 2; k <= WIN; k++) begin
            p2 = 1;
            step();
            p2 = 0;
            check("win_s2", score2, k);
            check("win_en_low", enablePong, 0);
            if (k < WIN) run_pause("win_pause_en");
        end
        check("over_winner", winner, 2'b10);
        step();
        p1 = 1; step(); p1 = 0; step();
        p2 = 1; step(); p2 = 0; step();
        check("over_s1_held", score1, 1);
        check("over_s2_held", score2, WIN);
        check("over_win_held", winner, 2'b10);
        check("over_en", enablePong, 0);
        start_btn = 1; step(); start_btn = 0;
        wait_play("restart_en");
        check("restart_s1", score1, 0);
        check("restart_s2", score2, 0);
        check("restart_win", winner, 0);

        // Reset in the middle of a pause with score1 = 3
        for (int k = 1; k <= 3; k++) begin
            p1 = 1;
            step();
            p1 = 0;
            check("pre_rst_s1", score1, k);
            if (k < 3) run_pause("pre_rst_pause_en");
        end
        for (int i = 0; i < 5; i++) begin
            drive_raster(1); step(); drive_raster(0); step();
        end
        #2 i_rst = 1'b0;
        #1;
        check("midrst_en", enablePong, 0);
        check("midrst_s1", score1, 0);
        check("midrst_s2", score2, 0);
        check("midrst_win", winner, 0);
        @(negedge clk_in);
        i_rst = 1'b1;
        repeat (5) step();
        check("idle_en", enablePong, 0);
        start_btn = 1; step(); start_btn = 0;
        check("start_not_instant", enablePong, 0);
        wait_play("idle_start_en");
        check("idle_start_s1", score1, 0);

        // Raster sweep: all of x on a subset of lines, two frames
        ys = '{0, 1, 240, 478, 479};
        ticks = 0;
        bad = 0;
        for (int f = 0; f < 2; f++) begin
            foreach (ys[j]) begin
                for (int x = 0; x < 640; x++) begin
                    o_x = 10'(x);
                    o_y = 9'(ys[j]);
                    step();
                    if (frame_tick) ticks++;
                    if (frame_tick != ((x == 639) && (ys[j] == 479))) bad++;
                end
            end
        end
        check("sweep_tick_count", ticks, 2);
        check("sweep_tick_misplaced", bad, 0);

        // Randomised play against the reference model
        drive_raster(0);
        @(negedge clk_in);
        #2 i_rst = 1'b0;
        @(negedge clk_in);
        i_rst = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            step();
            check("rnd_en", enablePong, m_play);
            check("rnd_s1", score1, m_s1);
            check("rnd_s2", score2, m_s2);
            check("rnd_win", winner, m_win);
            check("rnd_ft", frame_tick, m_ft);
`ifdef SEG7_EN
            check("rnd_hex1", hex_p1, seg_ref(m_s1_d));
            check("rnd_hex2", hex_p2, seg_ref(m_s2_d));
`endif
            start_btn = ($urandom_range(0, 39) == 0);
            p1 = ($urandom_range(0, 5) == 0);
            p2 = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) begin
                o_x = 10'd639;
                o_y = 9'd479;
            end else begin
                o_x = 10'($urandom_range(0, 639));
                o_y = 9'($urandom_range(0, 478));
            end
            if (!i_rst) i_rst = 1'b1;
            else if ($urandom_range(0, 4999) == 0) i_rst = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
